// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer: state encodings,
// the BCD HH:MM time width and seconds-per-minute.
`timescale 1ns/1ps
package alarm_pkg;

  localparam int TIME_W      = 16;
  localparam int SEC_PER_MIN = 60;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_RINGING = 2'b10,
    ST_SNOOZE  = 2'b11
  } alarm_state_t;

endpackage

// File: rtl/alarm_match_detect.sv
// Detects the first cycle in which the current time equals the alarm setting.
// match_q resets high so the block never sees a rise straight out of reset.
`timescale 1ns/1ps
module alarm_match_detect
  import alarm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [TIME_W-1:0] alarm_time,
  output logic              match_rise
);

  logic match;
  logic match_q;

  assign match      = (cur_time == alarm_time);
  assign match_rise = match & ~match_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b1;
    end else begin
      match_q <= match;
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring / snooze / dismiss / auto-timeout controller driven by a 1 Hz tick.
// Optional snooze limit per alarm event: define ALARM_SEQ_SNOOZE_LIMIT_EN.
`timescale 1ns/1ps
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MINUTES   = 9,
  parameter int RING_TIMEOUT_SEC = 300,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Sec_Pulse,
  input  logic [TIME_W-1:0] i_Time,
  input  logic [TIME_W-1:0] i_Alarm_Time,
  input  logic              i_Alarm_Enable,
  input  logic              i_Snooze,
  input  logic              i_Dismiss,
  output logic              o_Alarm_On,
  output logic              o_Snoozing,
  output logic [1:0]        o_State
);

  localparam int SNZ_LOAD = SNOOZE_MINUTES * SEC_PER_MIN;
  localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);
  localparam int RING_W   = $clog2(RING_TIMEOUT_SEC + 1);

  localparam logic [SNZ_W-1:0]  SNZ_LOAD_V = SNZ_W'(SNZ_LOAD);
  localparam logic [SNZ_W-1:0]  SNZ_ONE    = SNZ_W'(1);
  localparam logic [RING_W-1:0] RING_LAST  = RING_W'(RING_TIMEOUT_SEC - 1);

  alarm_state_t      state;
  alarm_state_t      next_state;
  logic              match_rise;
  logic [RING_W-1:0] ring_cnt;
  logic [SNZ_W-1:0]  snz_cnt;
  logic              ring_clr;
  logic              ring_inc;
  logic              snz_load;
  logic              snz_dec;
  logic              snooze_ok;

  alarm_match_detect u_match (
    .clk        (i_Clk),
    .rst        (i_Reset),
    .cur_time   (i_Time),
    .alarm_time (i_Alarm_Time),
    .match_rise (match_rise)
  );

`ifdef ALARM_SEQ_SNOOZE_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_SNOOZE + 1);

  logic [CNT_W-1:0] snooze_num;

  assign snooze_ok = (snooze_num < CNT_W'(MAX_SNOOZE));

  // Snoozes taken in the current alarm event; a new event starts from ARMED.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      snooze_num <= '0;
    end else if (next_state == ST_IDLE || next_state == ST_ARMED) begin
      snooze_num <= '0;
    end else if (snz_load) begin
      snooze_num <= snooze_num + CNT_W'(1);
    end
  end
`else
  assign snooze_ok = 1'b1;
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Disable wins over everything; user pulses outrank the second tick.
  always_comb begin
    next_state = state;
    ring_clr   = 1'b0;
    ring_inc   = 1'b0;
    snz_load   = 1'b0;
    snz_dec    = 1'b0;
    if (!i_Alarm_Enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: next_state = ST_ARMED;
        ST_ARMED: begin
          if (match_rise) begin
            next_state = ST_RINGING;
            ring_clr   = 1'b1;
          end
        end
        ST_RINGING: begin
          if (i_Dismiss) begin
            next_state = ST_ARMED;
          end else if (i_Snooze && snooze_ok) begin
            next_state = ST_SNOOZE;
            snz_load   = 1'b1;
          end else if (i_Sec_Pulse) begin
            if (ring_cnt == RING_LAST) begin
              next_state = ST_ARMED;
            end else begin
              ring_inc = 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (i_Dismiss) begin
            next_state = ST_ARMED;
          end else if (i_Sec_Pulse) begin
            if (snz_cnt == SNZ_ONE) begin
              next_state = ST_RINGING;
              ring_clr   = 1'b1;
            end else begin
              snz_dec = 1'b1;
            end
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else begin
      if (ring_clr) begin
        ring_cnt <= '0;
      end else if (ring_inc) begin
        ring_cnt <= ring_cnt + RING_W'(1);
      end
      if (snz_load) begin
        snz_cnt <= SNZ_LOAD_V;
      end else if (snz_dec) begin
        snz_cnt <= snz_cnt - SNZ_ONE;
      end
    end
  end

  assign o_Alarm_On = (state == ST_RINGING);
  assign o_Snoozing = (state == ST_SNOOZE);
  assign o_State    = state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios plus random traffic,
// all checked every cycle against a seconds-remaining reference model.
`timescale 1ns/1ps
module tb_alarm_sequencer;

  localparam int RING_SEC    = 5;
  localparam int SNOOZE_SEC  = 60;
  localparam int SNOOZE_CAP  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sec_pulse;
  logic [15:0] cur_time;
  logic [15:0] alarm_time;
  logic        enable;
  logic        snooze;
  logic        dismiss;
  logic        alarm_on;
  logic        snoozing;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing
  int m_mode;
  int m_left;
  int m_snoozes;
  bit m_prev_match;
  bit m_match;
  bit m_rise;

  alarm_sequencer #(
    .SNOOZE_MINUTES   (1),
    .RING_TIMEOUT_SEC (RING_SEC),
    .MAX_SNOOZE       (SNOOZE_CAP)
  ) dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_Sec_Pulse    (sec_pulse),
    .i_Time         (cur_time),
    .i_Alarm_Time   (alarm_time),
    .i_Alarm_Enable (enable),
    .i_Snooze       (snooze),
    .i_Dismiss      (dismiss),
    .o_Alarm_On     (alarm_on),
    .o_Snoozing     (snoozing),
    .o_State        (state_dbg)
  );

  always #100 clk = ~clk;

  function automatic bit snooze_allowed(input int taken);
`ifdef ALARM_SEQ_SNOOZE_LIMIT_EN
    return taken < SNOOZE_CAP;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_left = 0; m_snoozes = 0; m_prev_match = 1'b1;
    end else begin
      m_match = (cur_time == alarm_time);
      m_rise = m_match && !m_prev_match;
      m_prev_match = m_match;
      if (!enable) begin
        m_mode = 0; m_snoozes = 0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_snoozes = 0;
      end else if (m_mode == 1) begin
        if (m_rise) begin m_mode = 2; m_left = RING_SEC; end
      end else if (m_mode == 2) begin
        if (dismiss) begin
          m_mode = 1; m_snoozes = 0;
        end else if (snooze && snooze_allowed(m_snoozes)) begin
          m_mode = 3; m_left = SNOOZE_SEC; m_snoozes++;
        end else if (sec_pulse) begin
          m_left--;
          if (m_left == 0) begin m_mode = 1; m_snoozes = 0; end
        end
      end else begin
        if (dismiss) begin
          m_mode = 1; m_snoozes = 0;
        end else if (sec_pulse) begin
          m_left--;
          if (m_left == 0) begin m_mode = 2; m_left = RING_SEC; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (state_dbg !== 2'(m_mode) || alarm_on !== (m_mode == 2) || snoozing !== (m_mode == 3)) begin
        errors++;
        $display("[TB] FAIL model t=%0t: got state=%b on=%b snz=%b, expected state=%0d on=%0b snz=%0b",
                 $time, state_dbg, alarm_on, snoozing, m_mode, m_mode == 2, m_mode == 3);
      end
    end
  end

  task automatic apply_stimulus(input logic sec, input logic snz, input logic dis);
    sec_pulse = sec; snooze = snz; dismiss = dis;
    @(posedge clk); #1;
    sec_pulse = 1'b0; snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [1:0] exp_state);
    checks++;
    if (state_dbg !== exp_state || alarm_on !== (exp_state == 2'b10) || snoozing !== (exp_state == 2'b11)) begin
      errors++;
      $display("[TB] FAIL %s: got state=%b on=%b snz=%b, expected state=%b on=%b snz=%b", name,
               state_dbg, alarm_on, snoozing, exp_state, exp_state == 2'b10, exp_state == 2'b11);
    end
  endtask

  task automatic retrigger();
    cur_time = 16'h0731; apply_stimulus(0, 0, 0);
    cur_time = 16'h0730; apply_stimulus(0, 0, 0);
  endtask

  task automatic sec_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1, 0, 0);
      apply_stimulus(0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; sec_pulse = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    cur_time = 16'h0729; alarm_time = 16'h0730;
    #250 rst = 1'b0;
    @(posedge clk); #1;
    check_output("reset_idle", 2'b00);

    // Match rise rings one edge later; dismiss does not retrigger in same minute
    enable = 1'b1; apply_stimulus(0, 0, 0);
    check_output("armed", 2'b01);
    cur_time = 16'h0730; apply_stimulus(0, 0, 0);
    check_output("match_ring", 2'b10);
    apply_stimulus(0, 0, 1);
    check_output("dismiss", 2'b01);
    sec_pulses(3);
    check_output("no_retrigger", 2'b01);

    // Auto-off after exactly RING_SEC pulses
    retrigger();
    check_output("ring2", 2'b10);
    sec_pulses(RING_SEC - 1);
    check_output("ring_before_timeout", 2'b10);
    apply_stimulus(1, 0, 0);
    check_output("timeout", 2'b01);

    // Snooze for 60 pulses, then ring; dismiss beats snooze
    retrigger();
    apply_stimulus(0, 1, 0);
    check_output("snooze", 2'b11);
    sec_pulses(SNOOZE_SEC - 1);
    check_output("snooze_59", 2'b11);
    apply_stimulus(1, 0, 0);
    check_output("snooze_end", 2'b10);
    apply_stimulus(0, 1, 1);
    check_output("dismiss_and_snooze", 2'b01);

    // Third snooze within one event
    retrigger();
    apply_stimulus(0, 1, 0); sec_pulses(SNOOZE_SEC);
    apply_stimulus(0, 1, 0); sec_pulses(SNOOZE_SEC);
    check_output("after_two_snoozes", 2'b10);
    apply_stimulus(0, 1, 0);
`ifdef ALARM_SEQ_SNOOZE_LIMIT_EN
    check_output("third_snooze", 2'b10);
`else
    check_output("third_snooze", 2'b11);
`endif
    apply_stimulus(0, 0, 1);
    check_output("dismiss3", 2'b01);

    // Enable during matching minute, then disable mid-snooze
    enable = 1'b0; apply_stimulus(0, 0, 0);
    check_output("disable_idle", 2'b00);
    enable = 1'b1; apply_stimulus(0, 0, 0);
    sec_pulses(2);
    check_output("enable_in_match", 2'b01);
    retrigger();
    apply_stimulus(0, 1, 0);
    enable = 1'b0; apply_stimulus(1, 0, 0);
    check_output("disable_mid_snooze", 2'b00);

    // Asynchronous reset mid-ring
    enable = 1'b1; apply_stimulus(0, 0, 0);
    retrigger();
    check_output("ring_pre_reset", 2'b10);
    #50 rst = 1'b1;
    #1 check_output("async_reset", 2'b00);
    #30 rst = 1'b0;
    #1 check_output("after_release", 2'b00);
    apply_stimulus(0, 0, 0);
    check_output("rearm", 2'b01);

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      int r;
      enable = ($urandom_range(0, 99) < 97);
      r = $urandom_range(0, 99);
      if (r < 10) cur_time = 16'h0730;
      else if (r < 18) cur_time = 16'h0731;
      else if (r < 20) cur_time = 16'h1200;
      apply_stimulus($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                     $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
